// File: rtl/pingpong_loader_if.sv
// rtl/pingpong_loader_if.sv - producer/consumer handshake bundle for the ping-pong loader
//
// Signals:
//   wr_data/wr_valid/wr_ready : producer side, word captured on wr_valid && wr_ready
//   rd_ready/rd_valid         : consumer side, word retired on rd_valid && rd_ready
//   buf0/buf1                 : holding registers, feed mux in0/in1
//   sel                       : mux select (read pointer)
//   count                     : number of unread words, 0..2
// Modports:
//   master : producer/consumer (drives wr_data, wr_valid, rd_ready)
//   slave  : pingpong_loader
interface pingpong_loader_if #(
    parameter int WIDTH = 5
);
    logic [WIDTH-1:0] wr_data;
    logic             wr_valid;
    logic             wr_ready;
    logic             rd_ready;
    logic             rd_valid;
    logic [WIDTH-1:0] buf0;
    logic [WIDTH-1:0] buf1;
    logic             sel;
    logic [1:0]       count;

    modport master (
        output wr_data, wr_valid, rd_ready,
        input  wr_ready, rd_valid, buf0, buf1, sel, count
    );

    modport slave (
        input  wr_data, wr_valid, rd_ready,
        output wr_ready, rd_valid, buf0, buf1, sel, count
    );
endinterface

// File: rtl/pingpong_loader.sv
// rtl/pingpong_loader.sv - two-entry ping-pong buffer driving a 2:1 mux
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : synchronous active-low reset
//   bus   : pingpong_loader_if.slave
//             in : wr_data, wr_valid, rd_ready
//             out: wr_ready, rd_valid, buf0, buf1, sel, count
// Words are written alternately into buf0/buf1; sel follows the read pointer
// so the downstream mux always shows the oldest unread word. All outputs are
// decoded from registered state only.
module pingpong_loader #(
    parameter int WIDTH = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    pingpong_loader_if.slave    bus
);

    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       full;
    logic [WIDTH-1:0] buf0_q;
    logic [WIDTH-1:0] buf1_q;

    logic             wr_ptr_nxt;
    logic             rd_ptr_nxt;
    logic [1:0]       full_nxt;
    logic [WIDTH-1:0] buf0_nxt;
    logic [WIDTH-1:0] buf1_nxt;

    logic             wr_ready;
    logic             rd_valid;
    logic             wr_fire;
    logic             rd_fire;

    assign wr_ready = ~full[wr_ptr];
    assign rd_valid = full[rd_ptr];

    // wr_fire needs full[wr_ptr]==0 and rd_fire needs full[rd_ptr]==1, so the
    // two can never address the same buffer in one cycle. In FULL the write is
    // refused even when a read retires: space only shows up next cycle.
    assign wr_fire  = bus.wr_valid & wr_ready;
    assign rd_fire  = bus.rd_ready & rd_valid;

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        full_nxt   = full;
        buf0_nxt   = buf0_q;
        buf1_nxt   = buf1_q;

        if (wr_fire) begin
            full_nxt[wr_ptr] = 1'b1;
            wr_ptr_nxt       = ~wr_ptr;
            if (wr_ptr) begin
                buf1_nxt = bus.wr_data;
            end else begin
                buf0_nxt = bus.wr_data;
            end
        end

        // Read only clears the flag; the stale word stays visible on bufN.
        if (rd_fire) begin
            full_nxt[rd_ptr] = 1'b0;
            rd_ptr_nxt       = ~rd_ptr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            full   <= 2'b00;
            buf0_q <= '0;
            buf1_q <= '0;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= full_nxt;
            buf0_q <= buf0_nxt;
            buf1_q <= buf1_nxt;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid;
    assign bus.buf0     = buf0_q;
    assign bus.buf1     = buf1_q;
    assign bus.sel      = rd_ptr;
    assign bus.count    = {1'b0, full[0]} + {1'b0, full[1]};

endmodule

// File: doc/pingpong_loader.md
Name: pingpong_loader

Overview:
- Two-entry ping-pong buffer that sits directly upstream of the team's 2:1 multiplexor.
- Captures incoming words alternately into two holding registers, which drive the mux in0/in1 inputs.
- Drives the mux select with its read pointer, so mux_out always presents the oldest unread word.
- Valid/ready handshakes on both the write and read sides.

Parameters:
- WIDTH, 5, data width of wr_data, buf0 and buf1; matches the mux bus width.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  synchronous, active-low reset; sampled on the rising clk edge.
- wr_data  input  WIDTH  word offered by the producer.
- wr_valid  input  1  producer has a word on wr_data.
- wr_ready  output  1  a buffer is free; a write occurs when wr_valid && wr_ready.
- rd_ready  input  1  consumer accepts the word currently selected at mux_out.
- rd_valid  output  1  the selected buffer holds an unread word.
- buf0  output  WIDTH  holding register 0; connects to mux in0.
- buf1  output  WIDTH  holding register 1; connects to mux in1.
- sel  output  1  mux select; equals the read pointer (0 selects buf0, 1 selects buf1).
- count  output  2  number of unread words, 0..2.

Behaviour:
- Internal state:
  - wr_ptr, 1 bit.
  - rd_ptr, 1 bit.
  - full[1:0], one flag per buffer.
  - buf0, buf1.
- Reset (rst_n=0 at a rising edge): wr_ptr=0, rd_ptr=0, full=00, buf0=0, buf1=0. Outputs after reset: sel=0, rd_valid=0, wr_ready=1, count=0.
- Reset asserted mid-operation discards all stored words in that same edge. The wr_data/wr_valid/rd_ready values sampled in that cycle are ignored.
- All outputs are combinational decodes of registered state only; no input-to-output combinational path:
  - wr_ready = ~full[wr_ptr]
  - rd_valid = full[rd_ptr]
  - sel = rd_ptr
  - count = full[0] + full[1]
- Write (wr_valid && wr_ready): buf[wr_ptr] <= wr_data; full[wr_ptr] <= 1; wr_ptr toggles.
- Read (rd_valid && rd_ready): full[rd_ptr] <= 0; rd_ptr toggles.
  - Buffer contents are NOT cleared on read; the stale value remains visible on buf0/buf1.
- State view by count:
  - EMPTY (0): wr_ptr==rd_ptr, rd_valid=0. rd_ready is ignored; a read is never performed.
  - HALF (1): wr_ptr!=rd_ptr. Write and read may occur in the same cycle on different buffers; count stays 1 and both pointers toggle.
  - FULL (2): wr_ptr==rd_ptr, wr_ready=0. The write is blocked even if a read happens in the same cycle; no pass-through. Space appears on the following cycle.
- Write and read can never target the same buffer in one cycle.
- Latency: a word written at edge N gives rd_valid=1 and the word visible at mux_out after edge N (one cycle). There is no bypass from wr_data.
- Ordering: strict FIFO. Pointer wrap is the natural 1-bit toggle.
- wr_valid while wr_ready=0: no state change; the producer must hold the word.
- rd_ready while rd_valid=0: no state change.
- Buffer data and sel must be stable whenever rd_valid=1 and no read occurs.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with wr_valid=1, wr_data=5'h1F → buf0=buf1=0, sel=0, count=0, wr_ready=1, rd_valid=0.
- Single word: write 5'h0A with rd_ready=0 → next cycle buf0=0A, rd_valid=1, sel=0, count=1. Then assert rd_ready for 1 cycle → count=0, sel=1, buf0 still 0A.
- Fill and stall: write 5'h03 then 5'h1C with rd_ready=0 → count=2, wr_ready=0. Offer 5'h07 for 3 cycles → buffers stay 03/1C. One read then yields 03 at sel=0; wr_ready=1 on the next cycle.
- Streaming in HALF: preload 1 word, then hold wr_valid=rd_ready=1 for 8 cycles with values 1..8 → count stays 1, sel alternates every cycle, and the read sequence equals the write order.
- Simultaneous in FULL: count=2, wr_valid=1 (5'h11), rd_ready=1 → the read completes, the write is refused that cycle (count=1), and 5'h11 is accepted on the next cycle.
- Reset mid-stream: count=2 with buffers 05/06, assert rst_n=0 for 1 cycle → count=0, buf0=buf1=0, sel=0, and the first subsequent write lands in buf0.
